cr16_run_ctrl: RTL and testbench
================================

# cr16_run_ctrl

Parametrised run controller for the CR16 FPGA top level. It replaces the fixed warm-up clock gate and hard-wired PC limit with a clock-enable state machine. The state machine supports warm-up, run-to-limit, free-run, hardware breakpoint, single-step and hold modes. It also drives a registered, width-generic 7-segment display bus. It sits between the board inputs (switches and key), the CR16 core (`I_ENABLE`, `O_PC`, `O_RESULT_BUS`) and the BRAM debug port B. The CR16 clock is never gated.

## Interface
- P_WARMUP_CYCLES, 1: clock edges after reset with the CPU held disabled while BRAM outputs settle.
- P_NUM_DIGITS, 6: number of 4-bit hex digits on the display bus.
- P_COUNT_WIDTH, 32: width of the enabled-cycle counter.
- I_CLK  in  1  system clock; all state changes on the rising edge.
- I_NRESET  in  1  reset I_NRESET, asynchronous, active-low.
- I_MODE  in  2  00 LIMIT, 01 STEP, 10 FREE, 11 HOLD. Quasi-static switch input, sampled every cycle.
- I_STEP  in  1  step/resume key, asynchronous, active-high.
- I_MAX_PC  in  16  PC limit used in LIMIT mode.
- I_BREAK_EN  in  1  breakpoint enable.
- I_BREAK_PC  in  16  breakpoint address.
- I_PC  in  16  current CR16 program counter.
- I_RESULT_BUS  in  16  CR16 result bus.
- I_MEM_DATA_B  in  16  BRAM port-B read data.
- O_CPU_ENABLE  out  1  registered CR16 enable.
- O_STATE  out  3  0 WARMUP, 1 RUN, 2 STEP_WAIT, 3 STEP_PULSE, 4 HALT.
- O_HALT_REASON  out  2  00 none, 01 limit, 10 breakpoint, 11 hold.
- O_DISPLAY_BITS  out  4*P_NUM_DIGITS  registered hex digits; digit i occupies bits [4i+3:4i].
- O_RUN_CYCLES  out  P_COUNT_WIDTH  count of cycles with O_CPU_ENABLE high; saturates.

## Operation
- **Reset values:** state WARMUP, warm-up count 0, O_CPU_ENABLE 0, O_HALT_REASON 00, O_DISPLAY_BITS 0, O_RUN_CYCLES 0, synchroniser flops 0, skip flag 0.
- **Step edge detection:** I_STEP passes through a two-flop synchroniser plus a history flop. A "step edge" is sync2 & ~hist.
- **WARMUP:** on each edge, if the count equals P_WARMUP_CYCLES, leave WARMUP; otherwise increment the count. Exit destination by mode: LIMIT/FREE to RUN, STEP to STEP_WAIT, HOLD to HALT with reason 11. P_WARMUP_CYCLES=0 leaves WARMUP on the first edge.
- **RUN**, checked in priority order:
  - Mode HOLD: go to HALT, reason 11.
  - Mode STEP: go to STEP_WAIT.
  - Mode LIMIT and I_PC > I_MAX_PC (unsigned): go to HALT, reason 01.
  - Mode LIMIT or FREE, with I_BREAK_EN=1, I_PC == I_BREAK_PC and the skip flag clear: go to HALT, reason 10.
  - Otherwise stay in RUN.
- **STEP_WAIT:**
  - Mode HOLD: go to HALT, reason 11.
  - Mode LIMIT/FREE: go to RUN.
  - Step edge: go to STEP_PULSE.
- **STEP_PULSE:** always returns to STEP_WAIT after one cycle. The limit and breakpoint checks are not applied in STEP mode.
- **HALT:**
  - Reason 11: when the mode leaves HOLD, go to RUN (LIMIT/FREE) or STEP_WAIT (STEP), and clear the reason.
  - Reason 01/10: the state is sticky. A step edge resumes to the mode's state and clears the reason. Exception: a limit halt does not resume while the mode is LIMIT and I_PC > I_MAX_PC.
  - Mode HOLD: overrides the reason to 11.
- **Skip flag:** set when resuming from a breakpoint halt. Cleared when I_PC != I_BREAK_PC. While set, it masks the breakpoint compare.
- **O_CPU_ENABLE:** registered, equal to (next state == RUN or next state == STEP_PULSE).
- **O_DISPLAY_BITS:** registered.
  - In HALT (next state): I_MEM_DATA_B, zero-extended or truncated to 4*P_NUM_DIGITS.
  - Otherwise: the low 4*P_NUM_DIGITS bits of {I_PC, I_RESULT_BUS}, zero-extended if wider than 32.
- **O_RUN_CYCLES:** increments by 1 each edge where O_CPU_ENABLE is currently 1. Holds at all-ones.

## Timing
- **Warm-up:** with P_WARMUP_CYCLES=W and mode LIMIT, O_CPU_ENABLE first goes high after reset edge W+1.
- **Halt latency:** the halt condition is evaluated combinationally on I_PC. O_CPU_ENABLE drops after the same edge that enters HALT, one cycle later. The CPU therefore sees exactly one more enabled edge after the offending PC appears.
- **Step latency:** if I_STEP is first sampled high at edge k, STEP_PULSE is entered at edge k+2. O_CPU_ENABLE is high for exactly the one cycle between edges k+2 and k+3. A held I_STEP produces one pulse only.
- **Display latency:** 1 cycle.
- **Reset mid-operation:** asynchronous reset immediately forces all reset values, including O_CPU_ENABLE=0.

## Test plan
- **Warm-up and limit:** reset, mode LIMIT, W=1, I_MAX_PC=20, I_PC ramps +1 per enabled cycle.
  - Required: enable high after edge 2.
  - Required: HALT with reason 01 when I_PC=21; display shows I_MEM_DATA_B; O_RUN_CYCLES stops.
- **Single step:** mode STEP, three I_STEP presses each held for 10 cycles.
  - Required: three one-cycle enable pulses, each 2 edges after sampling, and O_RUN_CYCLES=3.
- **Breakpoint and resume:** FREE, I_BREAK_PC=0x0008.
  - Required: halt with reason 10 at PC 8.
  - Required: a step edge resumes, PC advances to 9 without re-halting, and the break recurs when PC later returns to 8.
- **Hold:** RUN, then I_MODE=11.
  - Required: HALT with reason 11 within one edge.
  - Required: I_MODE=10 returns to RUN, with enable high the following cycle.
- **Display packing:** I_PC=0x12AB, I_RESULT_BUS=0xCDEF, P_NUM_DIGITS=6.
  - Required: O_DISPLAY_BITS=0xABCDEF.
  - Required: P_NUM_DIGITS=4 gives 0xCDEF.
- **Mid-run reset:** assert I_NRESET low while in STEP_PULSE.
  - Required: O_CPU_ENABLE=0 and O_STATE=0 with no clock edge, then the warm-up repeats.

Source files
------------

// File: rtl/cr16_run_ctrl.sv
// cr16_run_ctrl: clock-enable run controller for the CR16 FPGA top level.
// Sequences warm-up, limit/free running, hardware breakpoints, single-step
// and hold through a registered CPU enable (the CPU clock is never gated),
// counts enabled cycles and drives a registered hex display bus.
module cr16_run_ctrl #(
    parameter int P_WARMUP_CYCLES = 1,
    parameter int P_NUM_DIGITS    = 6,
    parameter int P_COUNT_WIDTH   = 32
) (
    input  logic                      I_CLK,
    input  logic                      I_NRESET,
    input  logic [1:0]                I_MODE,
    input  logic                      I_STEP,
    input  logic [15:0]               I_MAX_PC,
    input  logic                      I_BREAK_EN,
    input  logic [15:0]               I_BREAK_PC,
    input  logic [15:0]               I_PC,
    input  logic [15:0]               I_RESULT_BUS,
    input  logic [15:0]               I_MEM_DATA_B,
    output logic                      O_CPU_ENABLE,
    output logic [2:0]                O_STATE,
    output logic [1:0]                O_HALT_REASON,
    output logic [4*P_NUM_DIGITS-1:0] O_DISPLAY_BITS,
    output logic [P_COUNT_WIDTH-1:0]  O_RUN_CYCLES
);

    localparam int DISP_W = 4 * P_NUM_DIGITS;
    localparam int WARM_W = (P_WARMUP_CYCLES < 1) ? 1 : $clog2(P_WARMUP_CYCLES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(P_WARMUP_CYCLES);

    localparam logic [1:0] MODE_LIMIT = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_FREE  = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic [1:0] REASON_NONE  = 2'b00;
    localparam logic [1:0] REASON_LIMIT = 2'b01;
    localparam logic [1:0] REASON_BREAK = 2'b10;
    localparam logic [1:0] REASON_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        ST_WARMUP     = 3'd0,
        ST_RUN        = 3'd1,
        ST_STEP_WAIT  = 3'd2,
        ST_STEP_PULSE = 3'd3,
        ST_HALT       = 3'd4
    } state_t;

    state_t              state_q, state_d;
    state_t              home_state;
    logic [1:0]          reason_q, reason_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic                skip_q, skip_d;
    logic                cpu_enable_q, cpu_enable_d;
    logic [DISP_W-1:0]   display_q, display_d;
    logic [P_COUNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
    logic                step_sync1_q, step_sync1_d;
    logic                step_sync2_q, step_sync2_d;
    logic                step_hist_q, step_hist_d;

    logic                step_edge;
    logic                pc_over_limit;
    logic                break_hit;
    logic                resume_from_break;

    // Qualifiers shared by the state machine: key edge, limit overrun, breakpoint match.
    always_comb begin
        step_edge     = step_sync2_q & ~step_hist_q;
        pc_over_limit = (I_MODE == MODE_LIMIT) && (I_PC > I_MAX_PC);
        break_hit     = I_BREAK_EN && (I_PC == I_BREAK_PC) && !skip_q;
        home_state    = (I_MODE == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
    end

    // Next-state, halt reason, breakpoint skip flag and registered output values.
    always_comb begin
        state_d           = state_q;
        reason_d          = reason_q;
        warm_cnt_d        = warm_cnt_q;
        skip_d            = skip_q;
        resume_from_break = 1'b0;
        step_sync1_d      = I_STEP;
        step_sync2_d      = step_sync1_q;
        step_hist_d       = step_sync2_q;

        case (state_q)
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    if (I_MODE == MODE_HOLD) begin
                        state_d  = ST_HALT;
                        reason_d = REASON_HOLD;
                    end else begin
                        state_d = home_state;
                    end
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (I_MODE == MODE_HOLD) begin
                    state_d  = ST_HALT;
                    reason_d = REASON_HOLD;
                end else if (I_MODE == MODE_STEP) begin
                    state_d = ST_STEP_WAIT;
                end else if (pc_over_limit) begin
                    state_d  = ST_HALT;
                    reason_d = REASON_LIMIT;
                end else if (break_hit) begin
                    state_d  = ST_HALT;
                    reason_d = REASON_BREAK;
                end
            end
            ST_STEP_WAIT: begin
                if (I_MODE == MODE_HOLD) begin
                    state_d  = ST_HALT;
                    reason_d = REASON_HOLD;
                end else if ((I_MODE == MODE_LIMIT) || (I_MODE == MODE_FREE)) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = ST_STEP_PULSE;
                end
            end
            ST_STEP_PULSE: begin
                state_d = ST_STEP_WAIT;
            end
            ST_HALT: begin
                if (I_MODE == MODE_HOLD) begin
                    reason_d = REASON_HOLD;
                end else if (reason_q == REASON_HOLD) begin
                    state_d  = home_state;
                    reason_d = REASON_NONE;
                end else if (step_edge && !((reason_q == REASON_LIMIT) && pc_over_limit)) begin
                    state_d           = home_state;
                    reason_d          = REASON_NONE;
                    resume_from_break = (reason_q == REASON_BREAK);
                end
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase

        if (resume_from_break) begin
            skip_d = 1'b1;
        end else if (I_PC != I_BREAK_PC) begin
            skip_d = 1'b0;
        end

        cpu_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP_PULSE);

        if (state_d == ST_HALT) begin
            display_d = DISP_W'(I_MEM_DATA_B);
        end else begin
            display_d = DISP_W'({I_PC, I_RESULT_BUS});
        end

        run_cycles_d = run_cycles_q;
        if (cpu_enable_q && !(&run_cycles_q)) begin
            run_cycles_d = run_cycles_q + P_COUNT_WIDTH'(1);
        end
    end

    // All controller state, with asynchronous active-low reset.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q      <= ST_WARMUP;
            reason_q     <= REASON_NONE;
            warm_cnt_q   <= '0;
            skip_q       <= 1'b0;
            cpu_enable_q <= 1'b0;
            display_q    <= '0;
            run_cycles_q <= '0;
            step_sync1_q <= 1'b0;
            step_sync2_q <= 1'b0;
            step_hist_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            reason_q     <= reason_d;
            warm_cnt_q   <= warm_cnt_d;
            skip_q       <= skip_d;
            cpu_enable_q <= cpu_enable_d;
            display_q    <= display_d;
            run_cycles_q <= run_cycles_d;
            step_sync1_q <= step_sync1_d;
            step_sync2_q <= step_sync2_d;
            step_hist_q  <= step_hist_d;
        end
    end

    assign O_CPU_ENABLE   = cpu_enable_q;
    assign O_STATE        = state_q;
    assign O_HALT_REASON  = reason_q;
    assign O_DISPLAY_BITS = display_q;
    assign O_RUN_CYCLES   = run_cycles_q;

endmodule

// File: tb/tb_cr16_run_ctrl.sv
// tb_cr16_run_ctrl: directed and randomized stimulus for cr16_run_ctrl,
// checked every cycle against a rule-level reference model of the controller.
module tb_cr16_run_ctrl;

    localparam int WARMUP = 1;
    localparam int CW     = 8;
    localparam int MAXC   = (1 << CW) - 1;

    localparam logic [1:0] M_LIMIT = 2'b00;
    localparam logic [1:0] M_STEP  = 2'b01;
    localparam logic [1:0] M_FREE  = 2'b10;
    localparam logic [1:0] M_HOLD  = 2'b11;

    localparam int S_WARMUP = 0;
    localparam int S_RUN    = 1;
    localparam int S_WAIT   = 2;
    localparam int S_PULSE  = 3;
    localparam int S_HALT   = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic [1:0]  mode = M_LIMIT;
    logic        step = 1'b0;
    logic [15:0] max_pc = 16'd20;
    logic        break_en = 1'b0;
    logic [15:0] break_pc = 16'd0;
    logic [15:0] pc = 16'd0;
    logic [15:0] result_bus = 16'd0;
    logic [15:0] mem_data = 16'd0;

    logic          cpu_enable, en9, en4;
    logic [2:0]    state, state9, state4;
    logic [1:0]    halt_reason, reason9, reason4;
    logic [23:0]   disp6;
    logic [35:0]   disp9;
    logic [15:0]   disp4;
    logic [CW-1:0] run_cycles, cycles9, cycles4;

    int n_checks = 0;
    int n_fails  = 0;
    bit rand_data = 1'b1;

    // Reference model state
    int          m_state, m_reason, m_cycles, m_since;
    bit          m_skip, m_en;
    logic [63:0] m_disp6, m_disp9;
    bit          step_q[$];

    cr16_run_ctrl #(.P_WARMUP_CYCLES(WARMUP), .P_NUM_DIGITS(6), .P_COUNT_WIDTH(CW)) dut (
        .I_CLK(clk), .I_NRESET(nreset), .I_MODE(mode), .I_STEP(step),
        .I_MAX_PC(max_pc), .I_BREAK_EN(break_en), .I_BREAK_PC(break_pc),
        .I_PC(pc), .I_RESULT_BUS(result_bus), .I_MEM_DATA_B(mem_data),
        .O_CPU_ENABLE(cpu_enable), .O_STATE(state), .O_HALT_REASON(halt_reason),
        .O_DISPLAY_BITS(disp6), .O_RUN_CYCLES(run_cycles)
    );

    cr16_run_ctrl #(.P_WARMUP_CYCLES(WARMUP), .P_NUM_DIGITS(9), .P_COUNT_WIDTH(CW)) dut9 (
        .I_CLK(clk), .I_NRESET(nreset), .I_MODE(mode), .I_STEP(step),
        .I_MAX_PC(max_pc), .I_BREAK_EN(break_en), .I_BREAK_PC(break_pc),
        .I_PC(pc), .I_RESULT_BUS(result_bus), .I_MEM_DATA_B(mem_data),
        .O_CPU_ENABLE(en9), .O_STATE(state9), .O_HALT_REASON(reason9),
        .O_DISPLAY_BITS(disp9), .O_RUN_CYCLES(cycles9)
    );

    cr16_run_ctrl #(.P_WARMUP_CYCLES(0), .P_NUM_DIGITS(4), .P_COUNT_WIDTH(CW)) dut4 (
        .I_CLK(clk), .I_NRESET(nreset), .I_MODE(mode), .I_STEP(step),
        .I_MAX_PC(max_pc), .I_BREAK_EN(break_en), .I_BREAK_PC(break_pc),
        .I_PC(pc), .I_RESULT_BUS(result_bus), .I_MEM_DATA_B(mem_data),
        .O_CPU_ENABLE(en4), .O_STATE(state4), .O_HALT_REASON(reason4),
        .O_DISPLAY_BITS(disp4), .O_RUN_CYCLES(cycles4)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, observed no end, expected end of test");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Display content: memory word while halted, otherwise {PC, result}, masked to the bus width
    function automatic logic [63:0] dispModel(input int digits, input bit halted);
        logic [63:0] mask;
        mask = (64'd1 << (4 * digits)) - 64'd1;
        if (halted) return {48'd0, mem_data} & mask;
        return {32'd0, pc, result_bus} & mask;
    endfunction

    function automatic int homeState(input logic [1:0] md);
        return (md == M_STEP) ? S_WAIT : S_RUN;
    endfunction

    task automatic modelReset();
        m_state = S_WARMUP; m_reason = 0; m_cycles = 0; m_since = 0;
        m_skip = 1'b0; m_en = 1'b0; m_disp6 = 64'd0; m_disp9 = 64'd0;
        step_q = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic checkOutput();
        checkValue("state",    64'(state),       64'(m_state));
        checkValue("enable",   64'(cpu_enable),  64'(m_en));
        checkValue("reason",   64'(halt_reason), 64'(m_reason));
        checkValue("cycles",   64'(run_cycles),  64'(m_cycles));
        checkValue("display6", 64'(disp6),       m_disp6);
        checkValue("display9", 64'(disp9),       m_disp9);
        checkValue("enable9",  64'(en9),         64'(m_en));
    endtask

    // One clock edge: predict from the pre-edge inputs, clock, compare, then advance the CPU PC
    task automatic applyStimulus();
        int ns, nr;
        bit nskip, edge_seen, over, hit, break_resume, old_en;
        logic [63:0] nd6, nd9;
        if (rand_data) begin
            result_bus = 16'($urandom);
            mem_data   = 16'($urandom);
        end
        edge_seen = step_q[1] && !step_q[0];
        over = (mode == M_LIMIT) && (pc > max_pc);
        hit  = ((mode == M_LIMIT) || (mode == M_FREE)) && break_en && (pc == break_pc) && !m_skip;
        ns = m_state; nr = m_reason; break_resume = 1'b0;
        case (m_state)
            S_WARMUP: if (m_since == WARMUP) begin
                if (mode == M_HOLD) begin ns = S_HALT; nr = 3; end
                else ns = homeState(mode);
            end
            S_RUN: begin
                if (mode == M_HOLD) begin ns = S_HALT; nr = 3; end
                else if (mode == M_STEP) ns = S_WAIT;
                else if (over) begin ns = S_HALT; nr = 1; end
                else if (hit) begin ns = S_HALT; nr = 2; end
            end
            S_WAIT: begin
                if (mode == M_HOLD) begin ns = S_HALT; nr = 3; end
                else if (mode != M_STEP) ns = S_RUN;
                else if (edge_seen) ns = S_PULSE;
            end
            S_PULSE: ns = S_WAIT;
            default: begin
                if (mode == M_HOLD) nr = 3;
                else if (m_reason == 3) begin ns = homeState(mode); nr = 0; end
                else if (edge_seen && !((m_reason == 1) && over)) begin
                    ns = homeState(mode); nr = 0; break_resume = (m_reason == 2);
                end
            end
        endcase
        nskip = break_resume ? 1'b1 : ((pc != break_pc) ? 1'b0 : m_skip);
        nd6 = dispModel(6, ns == S_HALT);
        nd9 = dispModel(9, ns == S_HALT);
        old_en = m_en;
        @(posedge clk);
        #1;
        m_state = ns; m_reason = nr; m_skip = nskip;
        m_en = (ns == S_RUN) || (ns == S_PULSE);
        if (old_en && (m_cycles < MAXC)) m_cycles++;
        m_disp6 = nd6; m_disp9 = nd9;
        step_q.push_back(step);
        void'(step_q.pop_front());
        m_since++;
        checkOutput();
        if (old_en) pc = pc + 16'd1;
    endtask

    // Asynchronous reset: outputs must clear with no clock edge
    task automatic doReset();
        nreset = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkValue("reset_state4",  64'(state4), 64'd0);
        checkValue("reset_enable4", 64'(en4),    64'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        // Warm-up and limit
        $display("[TB] warm-up and limit");
        mode = M_LIMIT; max_pc = 16'd20; pc = 16'd0;
        #3;
        doReset();
        applyStimulus();
        checkValue("warm_edge1_en", 64'(cpu_enable), 64'd0);
        applyStimulus();
        checkValue("warm_edge2_en", 64'(cpu_enable), 64'd1);
        for (int i = 0; i < 60 && m_state != S_HALT; i++) applyStimulus();
        checkValue("limit_state",  64'(state),       64'd4);
        checkValue("limit_reason", 64'(halt_reason), 64'd1);
        checkValue("limit_disp",   64'(disp6),       {48'd0, mem_data});
        for (int i = 0; i < 5; i++) applyStimulus();
        checkValue("limit_cycles_frozen", 64'(run_cycles), 64'd22);
        step = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        step = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus();
        checkValue("limit_no_resume", 64'(state), 64'd4);
        mode = M_FREE; step = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkValue("limit_resume_state",  64'(state),       64'd1);
        checkValue("limit_resume_reason", 64'(halt_reason), 64'd0);
        step = 1'b0;

        // Single step, three presses held for 10 cycles
        $display("[TB] single step");
        mode = M_STEP;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus();
        checkValue("step_wait_state", 64'(state), 64'd2);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            for (int c = 0; c < 10; c++) begin
                applyStimulus();
                checkValue("step_pulse", 64'(cpu_enable), 64'(c == 2));
            end
            step = 1'b0;
            for (int g = 0; g < int'($urandom_range(4, 8)); g++) applyStimulus();
        end
        checkValue("step_cycles", 64'(run_cycles), 64'd3);

        // Reset while in STEP_PULSE, then warm-up again
        $display("[TB] mid-run reset");
        step = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkValue("pulse_state", 64'(state), 64'd3);
        doReset();
        checkValue("midreset_enable", 64'(cpu_enable), 64'd0);
        checkValue("midreset_state",  64'(state),      64'd0);
        step = 1'b0;
        applyStimulus();
        checkValue("rewarm_edge1_state", 64'(state), 64'd0);
        applyStimulus();
        checkValue("rewarm_edge2_state", 64'(state), 64'd2);

        // Breakpoint, resume past it, recur
        $display("[TB] breakpoint");
        mode = M_FREE; break_en = 1'b1; break_pc = 16'h0008; pc = 16'd0;
        doReset();
        for (int i = 0; i < 40 && m_state != S_HALT; i++) applyStimulus();
        checkValue("break_state",  64'(state),       64'd4);
        checkValue("break_reason", 64'(halt_reason), 64'd2);
        pc = 16'h0008;
        for (int i = 0; i < 2; i++) applyStimulus();
        checkValue("break_sticky", 64'(state), 64'd4);
        step = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkValue("break_resume_state",  64'(state),       64'd1);
        checkValue("break_resume_reason", 64'(halt_reason), 64'd0);
        applyStimulus();
        checkValue("break_skip_pc8", 64'(state), 64'd1);
        for (int i = 0; i < 20 && pc != 16'd12; i++) applyStimulus();
        checkValue("break_past_state", 64'(state), 64'd1);
        pc = 16'd5;
        for (int i = 0; i < 20 && m_state != S_HALT; i++) applyStimulus();
        checkValue("break_recur_state",  64'(state),       64'd4);
        checkValue("break_recur_reason", 64'(halt_reason), 64'd2);
        step = 1'b0;

        // Hold
        $display("[TB] hold");
        break_en = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus();
        step = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        step = 1'b0;
        checkValue("hold_pre_run", 64'(state), 64'd1);
        mode = M_HOLD;
        applyStimulus();
        checkValue("hold_state",  64'(state),       64'd4);
        checkValue("hold_reason", 64'(halt_reason), 64'd3);
        for (int i = 0; i < 2; i++) applyStimulus();
        mode = M_FREE;
        applyStimulus();
        checkValue("hold_exit_state",  64'(state),      64'd1);
        checkValue("hold_exit_enable", 64'(cpu_enable), 64'd1);

        // Display packing for 6, 9 and 4 digits, then counter saturation
        $display("[TB] display packing and saturation");
        rand_data = 1'b0;
        pc = 16'h12AB; result_bus = 16'hCDEF; mem_data = 16'h5A5A;
        doReset();
        applyStimulus();
        checkValue("pack_disp6", 64'(disp6), 64'hAB_CDEF);
        checkValue("pack_disp9", 64'(disp9), 64'h0_12AB_CDEF);
        checkValue("pack_disp4", 64'(disp4), 64'hCDEF);
        checkValue("w0_enable4", 64'(en4),    64'd1);
        checkValue("w0_state4",  64'(state4), 64'd1);
        rand_data = 1'b1;
        for (int i = 0; i < 300; i++) applyStimulus();
        checkValue("cycles_saturated", 64'(run_cycles), 64'(MAXC));

        // Randomized operation
        $display("[TB] random phase");
        mode = M_LIMIT; pc = 16'd0; max_pc = 16'd20; break_en = 1'b1; break_pc = 16'd12;
        doReset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step = ~step;
            if ($urandom_range(0, 49) == 0) begin
                break_en = 1'($urandom_range(0, 1));
                break_pc = 16'($urandom_range(0, 31));
                max_pc   = 16'($urandom_range(8, 40));
            end
            if ($urandom_range(0, 31) == 0) pc = 16'($urandom_range(0, 31));
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
